// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Takes one accept cycle plus WIDTH iterations; divide-by-zero and signed overflow finish in one cycle.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state;
  logic [1:0]       op_q;
  logic             sign_a;
  logic             sign_b;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] div_mag;
  logic [CW-1:0]    counter;

  logic             a_neg, b_neg, div_zero, ovf;
  logic [WIDTH-1:0] a_mag, b_mag, special_res;
  logic [WIDTH:0]   rem_sh, trial;
  logic             fits;
  logic [WIDTH-1:0] rem_next, quo_next, q_fixed, r_fixed;

  // Operand conditioning and early-out detection, evaluated on the raw inputs at accept.
  always_comb begin
    a_neg       = ~op[0] & a[WIDTH-1];
    b_neg       = ~op[0] & b[WIDTH-1];
    a_mag       = a_neg ? (~a + 1'b1) : a;
    b_mag       = b_neg ? (~b + 1'b1) : b;
    div_zero    = (b == '0);
    ovf         = ~op[0] & (a == MIN_NEG) & (b == '1);
    special_res = '0;
    if (div_zero)
      special_res = op[1] ? a : '1;
    else
      special_res = op[1] ? '0 : MIN_NEG;
  end

  // One restoring step; the partial remainder needs WIDTH+1 bits once shifted.
  always_comb begin
    rem_sh   = {rem, quo[WIDTH-1]};
    trial    = rem_sh - {1'b0, div_mag};
    fits     = ~trial[WIDTH];
    rem_next = fits ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    quo_next = {quo[WIDTH-2:0], fits};
    q_fixed  = ((op_q == 2'b00) && (sign_a ^ sign_b)) ? (~quo_next + 1'b1) : quo_next;
    r_fixed  = ((op_q == 2'b10) && sign_a) ? (~rem_next + 1'b1) : rem_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      op_q    <= '0;
      sign_a  <= 1'b0;
      sign_b  <= 1'b0;
      rem     <= '0;
      quo     <= '0;
      div_mag <= '0;
      counter <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done  <= 1'b0;
          state <= IDLE;
          if (start) begin
            op_q    <= op;
            sign_a  <= a_neg;
            sign_b  <= b_neg;
            div_mag <= b_mag;
            rem     <= '0;
            quo     <= a_mag;
            counter <= '0;
            if (div_zero || ovf) begin
              result <= special_res;
              done   <= 1'b1;
              state  <= DONE;
            end else begin
              busy  <= 1'b1;
              state <= CALC;
            end
          end
        end
        CALC: begin
          rem     <= rem_next;
          quo     <= quo_next;
          counter <= counter + CW'(1);
          if (counter == CW'(WIDTH-1)) begin
            result  <= op_q[1] ? r_fixed : q_fixed;
            counter <= '0;
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed and randomized checks of div_unit against an arithmetic reference model.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int tests = 0;
  int fails = 0;

  div_unit #(.WIDTH(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  // Reference built from plain integer arithmetic on 64-bit values.
  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint      sx, sy;
    logic [63:0] t;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (y == 32'd0) return o[1] ? x : 32'hFFFF_FFFF;
    case (o)
      2'b00:   t = 64'(sx / sy);
      2'b01:   t = {32'd0, x / y};
      2'b10:   t = 64'(sx % sy);
      default: t = {32'd0, x % y};
    endcase
    return t[31:0];
  endfunction

  function automatic int model_latency(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    if (y == 32'd0) return 1;
    if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drives a request for one edge, then scrambles the inputs to prove they were captured.
  task automatic apply_stimulus(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(posedge clk);
    #1;
    start = 1'b0;
    op    = 2'($urandom);
    a     = $urandom;
    b     = $urandom;
  endtask

  task automatic wait_done(output logic [31:0] res, output int cyc, output int busy_cyc,
                           output int overlap, input int inject_at);
    cyc      = 0;
    busy_cyc = 0;
    overlap  = 0;
    while (cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (busy) busy_cyc++;
      if (busy && done) overlap++;
      if (done) break;
      if (cyc == inject_at) begin
        start = 1'b1;
        op    = 2'b01;
        a     = 32'd9;
        b     = 32'd3;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    res   = result;
  endtask

  task automatic run_case(input string tag, input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] exp_res, input int exp_cyc);
    logic [31:0] res;
    int          cyc, busy_cyc, overlap;
    apply_stimulus(o, x, y);
    wait_done(res, cyc, busy_cyc, overlap, -1);
    check_output({tag, "_result"}, res, exp_res);
    check_output({tag, "_latency"}, 32'(cyc), 32'(exp_cyc));
    check_output({tag, "_busy_cycles"}, 32'(busy_cyc), (exp_cyc == 1) ? 32'd0 : 32'd32);
    check_output({tag, "_overlap"}, 32'(overlap), 32'd0);
    @(negedge clk);
    check_output({tag, "_hold"}, result, exp_res);
    check_output({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    logic [31:0] res, x, y;
    logic [1:0]  o;
    int          cyc, busy_cyc, overlap, done_seen, busy_seen;

    rst_n = 1'b0;
    start = 1'b0;
    op    = 2'b00;
    a     = 32'd0;
    b     = 32'd0;
    @(negedge clk);
    check_output("reset_busy", {31'd0, busy}, 32'd0);
    check_output("reset_done", {31'd0, done}, 32'd0);
    check_output("reset_result", result, 32'd0);
    #3 rst_n = 1'b1;
    @(negedge clk);

    run_case("divu_100_7", 2'b01, 32'd100, 32'd7, 32'd14, 33);
    run_case("remu_100_7", 2'b11, 32'd100, 32'd7, 32'd2, 33);
    run_case("div_m7_2",   2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    run_case("rem_m7_2",   2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    run_case("rem_7_m2",   2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 33);
    run_case("divu_by0",   2'b01, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    run_case("rem_by0",    2'b10, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 1);
    run_case("div_ovf",    2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_case("rem_ovf",    2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);

    // A start pulse during CALC must neither restart nor recapture operands.
    apply_stimulus(2'b01, 32'd100, 32'd7);
    wait_done(res, cyc, busy_cyc, overlap, 10);
    check_output("ignored_start_result", res, 32'd14);
    check_output("ignored_start_latency", 32'(cyc), 32'd33);

    // Issue again in the DONE cycle: no idle bubble between the two operations.
    apply_stimulus(2'b01, 32'd9, 32'd3);
    check_output("b2b_done_dropped", {31'd0, done}, 32'd0);
    check_output("b2b_busy_rose", {31'd0, busy}, 32'd1);
    check_output("b2b_old_result_held", result, 32'd14);
    wait_done(res, cyc, busy_cyc, overlap, -1);
    check_output("b2b_result", res, 32'd3);
    check_output("b2b_latency", 32'(cyc), 32'd33);
    @(negedge clk);

    // Asynchronous reset in the middle of CALC.
    apply_stimulus(2'b01, 32'd100, 32'd7);
    repeat (14) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_output("abort_busy", {31'd0, busy}, 32'd0);
    check_output("abort_done", {31'd0, done}, 32'd0);
    check_output("abort_result", result, 32'd0);
    @(negedge clk);
    #3 rst_n = 1'b1;
    done_seen = 0;
    busy_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) done_seen++;
      if (busy) busy_seen++;
    end
    check_output("abort_no_done", 32'(done_seen), 32'd0);
    check_output("abort_no_busy", 32'(busy_seen), 32'd0);

    for (int i = 0; i < 60; i++) begin
      o = 2'($urandom);
      case ($urandom_range(0, 7))
        0:       y = 32'd0;
        1:       y = 32'hFFFF_FFFF;
        2:       y = $urandom_range(1, 15);
        3:       y = $urandom >> $urandom_range(0, 31);
        default: y = $urandom;
      endcase
      case ($urandom_range(0, 4))
        0:       x = 32'h8000_0000;
        1:       x = $urandom_range(0, 255);
        default: x = $urandom;
      endcase
      if (y == 32'd0 && $urandom_range(0, 1) == 1) y = 32'd1;
      run_case($sformatf("rand%0d_op%0d", i, o), o, x, y, model(o, x, y), model_latency(o, x, y));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
